// File: rtl/io_bus_fabric.sv
// IO bus fabric: decodes a slave slot from the master address and runs one
// transaction at a time with per-slave ready, timeout and decode-error response.
module io_bus_fabric #(
  parameter int NUM_SLAVES     = 3,
  parameter int SLOT_SHIFT     = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_req_valid,
  output logic                     m_req_ready,
  input  logic                     m_wr_en,
  input  logic [31:0]              m_address,
  input  logic [31:0]              m_wr_data,
  output logic                     m_rsp_valid,
  output logic                     m_rsp_err,
  output logic [31:0]              m_rd_data,
  output logic                     s_rd_en,
  output logic                     s_wr_en,
  output logic [NUM_SLAVES-1:0]    s_cs,
  output logic [31:0]              s_address,
  output logic [31:0]              s_wr_data,
  input  logic [NUM_SLAVES*32-1:0] s_rd_data,
  input  logic [NUM_SLAVES-1:0]    s_ready
);

  localparam int SEL_W = $clog2(NUM_SLAVES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]            state;
  logic [SEL_W-1:0]      slot;
  logic                  wr;
  logic [TO_W-1:0]       cnt;

  logic [SEL_W-1:0]      addr_slot;
  logic                  slot_ok;
  logic [NUM_SLAVES-1:0] onehot;
  logic                  sel_ready;
  logic [31:0]           sel_data;

  assign addr_slot = m_address[SLOT_SHIFT +: SEL_W];
  assign slot_ok   = {1'b0, addr_slot} < (SEL_W + 1)'(NUM_SLAVES);
  assign onehot    = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << addr_slot;

  // Only the latched slot's ready/data are visible; other slots are masked out.
  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (slot == SEL_W'(i)) begin
        sel_ready = s_ready[i];
        sel_data  = s_rd_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      slot        <= '0;
      wr          <= 1'b0;
      cnt         <= '0;
      m_req_ready <= 1'b0;
      m_rsp_valid <= 1'b0;
      m_rsp_err   <= 1'b0;
      m_rd_data   <= '0;
      s_rd_en     <= 1'b0;
      s_wr_en     <= 1'b0;
      s_cs        <= '0;
      s_address   <= '0;
      s_wr_data   <= '0;
    end else begin
      s_rd_en     <= 1'b0;
      s_wr_en     <= 1'b0;
      m_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (m_req_ready && m_req_valid) begin
            m_req_ready <= 1'b0;
            wr          <= m_wr_en;
            slot        <= addr_slot;
            s_address   <= m_address;
            s_wr_data   <= m_wr_data;
            cnt         <= TO_W'(1);
            if (slot_ok) begin
              state   <= ACCESS;
              s_cs    <= onehot;
              s_rd_en <= !m_wr_en;
              s_wr_en <= m_wr_en;
            end else begin
              state       <= RESP;
              m_rsp_valid <= 1'b1;
              m_rsp_err   <= 1'b1;
              m_rd_data   <= '0;
            end
          end else begin
            m_req_ready <= 1'b1;
          end
        end
        ACCESS, WAIT: begin
          // Ready is checked before the terminal count so a late ready still succeeds.
          if (sel_ready) begin
            state       <= RESP;
            s_cs        <= '0;
            m_rsp_valid <= 1'b1;
            m_rsp_err   <= 1'b0;
            m_rd_data   <= wr ? '0 : sel_data;
          end else if (cnt == TO_W'(TIMEOUT_CYCLES)) begin
            state       <= RESP;
            s_cs        <= '0;
            m_rsp_valid <= 1'b1;
            m_rsp_err   <= 1'b1;
            m_rd_data   <= '0;
          end else begin
            state <= WAIT;
            cnt   <= cnt + TO_W'(1);
          end
        end
        RESP: begin
          state       <= IDLE;
          m_req_ready <= 1'b1;
          m_rsp_err   <= 1'b0;
          m_rd_data   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_fabric.sv
// Directed table-driven bench for io_bus_fabric (3 slots, slot at bit 6, timeout 8).
module tb_io_bus_fabric;

  logic        clk;
  logic        rst;
  logic        m_req_valid;
  logic        m_req_ready;
  logic        m_wr_en;
  logic [31:0] m_address;
  logic [31:0] m_wr_data;
  logic        m_rsp_valid;
  logic        m_rsp_err;
  logic [31:0] m_rd_data;
  logic        s_rd_en;
  logic        s_wr_en;
  logic [2:0]  s_cs;
  logic [31:0] s_address;
  logic [31:0] s_wr_data;
  logic [95:0] s_rd_data;
  logic [2:0]  s_ready;

  int total;
  int bad;

  io_bus_fabric #(
    .NUM_SLAVES    (3),
    .SLOT_SHIFT    (6),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_req_valid(m_req_valid),
    .m_req_ready(m_req_ready),
    .m_wr_en    (m_wr_en),
    .m_address  (m_address),
    .m_wr_data  (m_wr_data),
    .m_rsp_valid(m_rsp_valid),
    .m_rsp_err  (m_rsp_err),
    .m_rd_data  (m_rd_data),
    .s_rd_en    (s_rd_en),
    .s_wr_en    (s_wr_en),
    .s_cs       (s_cs),
    .s_address  (s_address),
    .s_wr_data  (s_wr_data),
    .s_rd_data  (s_rd_data),
    .s_ready    (s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ready_at: access cycle (1 = ACCESS) in which the selected slot raises ready; 0 = never.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ready_at;
    logic [2:0]  noise;
    logic [2:0]  exp_cs;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_cs_cyc;
    int          exp_rdp;
    int          exp_wrp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the fabric idle; ends at the negedge after the response.
  task automatic run_vec(input int idx, input vec_t v);
    int k, lat, cs_bad, rdy_bad, addr_bad, rdp, wrp;
    logic got, err;
    logic [31:0] rd;
    k = 0; lat = 0; cs_bad = 0; rdy_bad = 0; addr_bad = 0; rdp = 0; wrp = 0;
    got = 1'b0; err = 1'b0; rd = '0;
    chk($sformatf("v%0d_req_ready", idx), {31'd0, m_req_ready}, 32'd1);
    m_req_valid = 1'b1;
    m_wr_en     = v.wr;
    m_address   = v.addr;
    m_wr_data   = v.wdata;
    s_ready     = v.noise;
    @(negedge clk);
    m_req_valid = 1'b0;
    m_wr_en     = 1'b0;
    m_address   = 32'hFFFF_FFFF;
    m_wr_data   = 32'hFFFF_FFFF;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (c > 1) @(negedge clk);
      if (s_rd_en) rdp++;
      if (s_wr_en) wrp++;
      if (m_req_ready) rdy_bad++;
      if (s_cs != 3'b000) begin
        if (s_cs != v.exp_cs) cs_bad++;
        if (s_address != v.addr || s_wr_data != v.wdata) addr_bad++;
        k++;
      end
      if (m_rsp_valid) begin
        got = 1'b1;
        lat = c;
        err = m_rsp_err;
        rd  = m_rd_data;
        if (s_cs != 3'b000) cs_bad++;
      end
      s_ready = v.noise | ((s_cs != 3'b000 && k == v.ready_at) ? v.exp_cs : 3'b000);
    end
    s_ready = 3'b000;
    chk($sformatf("v%0d_rsp_seen", idx), {31'd0, got}, 32'd1);
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_rd_data", idx), rd, v.exp_rd);
    chk($sformatf("v%0d_cs_cycles", idx), k, v.exp_cs_cyc);
    chk($sformatf("v%0d_cs_bad", idx), cs_bad, 0);
    chk($sformatf("v%0d_rd_pulses", idx), rdp, v.exp_rdp);
    chk($sformatf("v%0d_wr_pulses", idx), wrp, v.exp_wrp);
    chk($sformatf("v%0d_ready_busy", idx), rdy_bad, 0);
    chk($sformatf("v%0d_addr_during", idx), addr_bad, 0);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_drop", idx), {31'd0, m_rsp_valid}, 32'd0);
    chk($sformatf("v%0d_ready_back", idx), {31'd0, m_req_ready}, 32'd1);
    chk($sformatf("v%0d_s_address", idx), s_address, v.addr);
    chk($sformatf("v%0d_s_wr_data", idx), s_wr_data, v.wdata);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst         = 1'b1;
    m_req_valid = 1'b0;
    m_wr_en     = 1'b0;
    m_address   = '0;
    m_wr_data   = '0;
    s_ready     = 3'b000;
    s_rd_data   = {32'hCAFE_BEEF, 32'h1234_5678, 32'h0BAD_F00D};

    //          wr    addr          wdata         rdy noise   cs      lat err  rd            cs# rdp wrp
    vecs[0] = '{1'b0, 32'h0000_0040, 32'h0,        1, 3'b000, 3'b010, 2, 1'b0, 32'h1234_5678, 1, 1, 0};
    vecs[1] = '{1'b1, 32'h0000_0080, 32'hA5A5_0001, 6, 3'b000, 3'b100, 7, 1'b0, 32'h0,         6, 0, 1};
    vecs[2] = '{1'b0, 32'h0000_00C0, 32'h0,        1, 3'b000, 3'b000, 1, 1'b1, 32'h0,         0, 0, 0};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'h0,        0, 3'b000, 3'b001, 9, 1'b1, 32'h0,         8, 1, 0};
    vecs[4] = '{1'b0, 32'h0000_0004, 32'h0,        8, 3'b000, 3'b001, 9, 1'b0, 32'h0BAD_F00D, 8, 1, 0};
    vecs[5] = '{1'b0, 32'h0000_0010, 32'h0,        3, 3'b100, 3'b001, 4, 1'b0, 32'h0BAD_F00D, 3, 1, 0};
    vecs[6] = '{1'b1, 32'h0000_01C0, 32'h5555_AAAA, 1, 3'b111, 3'b000, 1, 1'b1, 32'h0,         0, 0, 0};
    vecs[7] = '{1'b0, 32'h0000_008C, 32'h0,        2, 3'b011, 3'b100, 3, 1'b0, 32'hCAFE_BEEF, 2, 1, 0};
    vecs[8] = '{1'b1, 32'h0000_0044, 32'h0000_0077, 1, 3'b000, 3'b010, 2, 1'b0, 32'h0,         1, 0, 1};

    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, m_req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    chk("rst_cs", {29'd0, s_cs}, 32'd0);
    chk("rst_strobes", {30'd0, s_rd_en, s_wr_en}, 32'd0);
    chk("rst_s_address", s_address, 32'd0);
    rst = 1'b1;
    #1 chk("rel_ready_before_edge", {31'd0, m_req_ready}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset while waiting on slot 1: abort with no response, accept again afterwards.
    m_req_valid = 1'b1;
    m_wr_en     = 1'b0;
    m_address   = 32'h0000_0040;
    @(negedge clk);
    m_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wait_cs", {29'd0, s_cs}, 32'h2);
    rst = 1'b0;
    #1;
    chk("abort_cs", {29'd0, s_cs}, 32'd0);
    chk("abort_ready", {31'd0, m_req_ready}, 32'd0);
    chk("abort_s_address", s_address, 32'd0);
    begin
      int rsp_seen;
      rsp_seen = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (m_rsp_valid) rsp_seen++;
      end
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        if (m_rsp_valid) rsp_seen++;
      end
      chk("abort_no_rsp", rsp_seen, 0);
    end
    run_vec(9, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
